// File: rtl/spi_pkg.sv
// Shared constants and types for the 40-bit SPI datagram target.
// Datagram layout, MSB first: {write, addr[6:0], data[31:0]}.
package spi_pkg;

  localparam int DATAGRAM_BITS = 40;
  localparam int ADDR_BITS     = 7;
  localparam int DATA_BITS     = 32;
  localparam int WRITE_BIT     = 39;
  localparam int CNT_BITS      = 6;

  localparam logic [ADDR_BITS-1:0] ERR_CLEAR_ADDR = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Status byte returned ahead of the read data in every reply.
  function automatic logic [7:0] status_byte(input logic err, input logic [3:0] id);
    return {err, 3'b000, id};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronised copy.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic reset_n_in,
  input  logic d_in,
  output logic rise_out,
  output logic fall_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_out = sync_q & ~prev_q;
  assign fall_out = ~sync_q & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-3 responder with a small register file and pipelined reads:
// the reply to each frame carries the register addressed by the previous good frame.
module spi_target
  import spi_pkg::*;
#(
  parameter int         SIZE      = DATAGRAM_BITS,
  parameter int         REG_COUNT = 16,
  parameter logic [3:0] STATUS_ID = 4'h5
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  input  logic                 sck_in,
  input  logic                 cs_n_in,
  input  logic                 serial_in,
  output logic                 serial_out,
  output logic                 r_serial_oe_out,
  output logic                 r_frame_valid_out,
  output logic                 r_write_out,
  output logic [ADDR_BITS-1:0] r_addr_out,
  output logic [DATA_BITS-1:0] r_data_out,
  output logic                 r_frame_err_out,
  input  logic [3:0]           reg_sel_in,
  output logic [DATA_BITS-1:0] reg_data_out
);

  localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [ADDR_BITS:0] REG_LIMIT = (ADDR_BITS + 1)'(REG_COUNT);

  function automatic logic in_range(input logic [ADDR_BITS-1:0] addr);
    return ({1'b0, addr} < REG_LIMIT);
  endfunction

  logic sck_rise, sck_fall, cs_rise, cs_fall;

  // CS resets to "selected" so a reset released mid-frame sees no falling
  // edge; the master's eventual CS rise then lands harmlessly in IDLE.
  sync_edge #(.RESET_VAL(1'b1)) u_sck_sync (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .d_in       (sck_in),
    .rise_out   (sck_rise),
    .fall_out   (sck_fall)
  );

  sync_edge #(.RESET_VAL(1'b0)) u_cs_sync (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .d_in       (cs_n_in),
    .rise_out   (cs_rise),
    .fall_out   (cs_fall)
  );

  state_e                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0]       in_q, in_d;
  logic [SIZE-1:0]       out_q, out_d;
  logic                  oe_q, oe_d;
  logic                  valid_q, valid_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  mosi_meta_q, mosi_meta_d;
  logic                  mosi_q, mosi_d;

  logic [DATA_BITS-1:0]  regs_q [REG_COUNT];
  logic [DATA_BITS-1:0]  regs_d [REG_COUNT];

  logic                  reg_we;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_BITS-1:0]  rd_data;
  logic [ADDR_BITS-1:0]  frame_addr;
  logic                  frame_write;
  logic [DATA_BITS-1:0]  frame_data;

  assign frame_write = in_q[WRITE_BIT];
  assign frame_addr  = in_q[WRITE_BIT-1 -: ADDR_BITS];
  assign frame_data  = in_q[DATA_BITS-1:0];
  assign wr_idx      = frame_addr[IDX_W-1:0];

  assign rd_data      = in_range(rd_addr_q) ? regs_q[rd_addr_q[IDX_W-1:0]] : '0;
  assign reg_data_out = ({1'b0, reg_sel_in} < 5'(REG_COUNT)) ? regs_q[reg_sel_in[IDX_W-1:0]] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_regs
      assign regs_d[gi] = (reg_we && (wr_idx == IDX_W'(gi))) ? frame_data : regs_q[gi];
    end
  endgenerate

  always_comb begin
    mosi_meta_d = serial_in;
    mosi_d      = mosi_meta_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_d      = in_q;
    out_d     = out_q;
    oe_d      = oe_q;
    valid_d   = 1'b0;
    write_d   = write_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    rd_addr_d = rd_addr_q;
    reg_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          out_d   = {status_byte(err_q, STATUS_ID), rd_data};
          oe_d    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (sck_rise) begin
          in_d = {in_q[SIZE-2:0], mosi_q};
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // The first falling edge precedes any sample, so the MSB must stay put.
        if (sck_fall && (cnt_q != '0)) begin
          out_d = {out_q[SIZE-2:0], 1'b0};
        end
        if (cs_rise) begin
          state_d = DONE;
        end
      end

      DONE: begin
        oe_d    = 1'b0;
        out_d   = '0;
        state_d = IDLE;
        if (cnt_q == CNT_BITS'(SIZE)) begin
          write_d   = frame_write;
          addr_d    = frame_addr;
          data_d    = frame_data;
          rd_addr_d = frame_addr;
          valid_d   = 1'b1;
          reg_we    = frame_write && in_range(frame_addr);
          if (frame_write && (frame_addr == ERR_CLEAR_ADDR)) begin
            err_d = 1'b0;
          end
        end else begin
          err_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_q        <= '0;
      out_q       <= '0;
      oe_q        <= 1'b0;
      valid_q     <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      rd_addr_q   <= '0;
      data_q      <= '0;
      mosi_meta_q <= 1'b0;
      mosi_q      <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_q        <= in_d;
      out_q       <= out_d;
      oe_q        <= oe_d;
      valid_q     <= valid_d;
      write_q     <= write_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      rd_addr_q   <= rd_addr_d;
      data_q      <= data_d;
      mosi_meta_q <= mosi_meta_d;
      mosi_q      <= mosi_d;
      regs_q      <= regs_d;
    end
  end

  assign serial_out        = out_q[SIZE-1];
  assign r_serial_oe_out   = oe_q;
  assign r_frame_valid_out = valid_q;
  assign r_write_out       = write_q;
  assign r_addr_out        = addr_q;
  assign r_data_out        = data_q;
  assign r_frame_err_out   = err_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a mode-3 SPI master model drives frames and
// checks replies, frame outputs, error handling, reset mid-frame and loopback.
module tb_spi_target;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sck;
  logic        cs_n;
  logic        mosi;
  logic        serial_out;
  logic        r_serial_oe_out;
  logic        r_frame_valid_out;
  logic        r_write_out;
  logic [6:0]  r_addr_out;
  logic [31:0] r_data_out;
  logic        r_frame_err_out;
  logic [3:0]  reg_sel;
  logic [31:0] reg_data_out;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulse_cnt = 0;
  logic oe_mid;

  spi_target dut (
    .clk_in            (clk),
    .reset_n_in        (reset_n),
    .sck_in            (sck),
    .cs_n_in           (cs_n),
    .serial_in         (mosi),
    .serial_out        (serial_out),
    .r_serial_oe_out   (r_serial_oe_out),
    .r_frame_valid_out (r_frame_valid_out),
    .r_write_out       (r_write_out),
    .r_addr_out        (r_addr_out),
    .r_data_out        (r_data_out),
    .r_frame_err_out   (r_frame_err_out),
    .reg_sel_in        (reg_sel),
    .reg_data_out      (reg_data_out)
  );

  always #5 clk = ~clk;

  // Counts every cycle the valid pulse is high, so a stretched pulse shows up.
  always @(negedge clk) begin
    if (r_frame_valid_out) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic spi_frame(input logic [39:0] tx, input int nbits, input int half,
                           output logic [39:0] rx);
    rx     = '0;
    oe_mid = 1'b0;
    cs_n   = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sck  = 1'b0;
      mosi = tx[39 - i];
      repeat (half) @(negedge clk);
      rx = {rx[38:0], serial_out};
      if (i == 0) oe_mid = r_serial_oe_out;
      sck = 1'b1;
      repeat (half) @(negedge clk);
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (2 * half) @(negedge clk);
  endtask

  task automatic xfer(input string tag, input logic [39:0] tx, input int nbits, input int half,
                      input logic [39:0] exp_rx, input int exp_pulses);
    logic [39:0] rx;
    int          p0;
    p0 = pulse_cnt;
    spi_frame(tx, nbits, half, rx);
    $display("frame %s: bits=%0d tx=%h rx=%h err=%0d", tag, nbits, tx, rx, r_frame_err_out);
    check({tag, ".miso"}, 64'(rx), 64'(exp_rx));
    check({tag, ".oe_mid"}, 64'(oe_mid), 64'd1);
    check({tag, ".oe_idle"}, 64'(r_serial_oe_out), 64'd0);
    check({tag, ".pulses"}, 64'(pulse_cnt - p0), 64'(exp_pulses));
  endtask

  logic [31:0] mregs [16];
  logic [3:0]  mlat;
  logic [3:0]  la;
  logic [31:0] ld;
  int          p0;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    cs_n    = 1'b1;
    sck     = 1'b1;
    mosi    = 1'b0;
    reg_sel = 4'd0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    check("rst.valid", 64'(r_frame_valid_out), 64'd0);
    check("rst.write", 64'(r_write_out), 64'd0);
    check("rst.addr", 64'(r_addr_out), 64'd0);
    check("rst.data", 64'(r_data_out), 64'd0);
    check("rst.err", 64'(r_frame_err_out), 64'd0);
    check("rst.oe", 64'(r_serial_oe_out), 64'd0);
    check("rst.miso", 64'(serial_out), 64'd0);
    check("rst.reg0", 64'(reg_data_out), 64'd0);

    // Reset defaults, then write reg 3 and read it back.
    xfer("f1_zero", 40'h00_00000000, 40, 6, 40'h05_00000000, 1);
    xfer("f2_wr3", 40'h83_DEADBEEF, 40, 6, 40'h05_00000000, 1);
    check("f2.write", 64'(r_write_out), 64'd1);
    check("f2.addr", 64'(r_addr_out), 64'h03);
    check("f2.data", 64'(r_data_out), 64'hDEADBEEF);
    reg_sel = 4'd3;
    @(negedge clk);
    check("f2.reg3", 64'(reg_data_out), 64'hDEADBEEF);
    xfer("f3_rd3", 40'h03_00000000, 40, 6, 40'h05_DEADBEEF, 1);
    check("f3.write", 64'(r_write_out), 64'd0);

    // 39-bit frame: reply truncated, flagged as error, nothing committed.
    xfer("f4_short", 40'h83_11111111, 39, 6, 40'h02_EF56DF77, 0);
    check("f4.err", 64'(r_frame_err_out), 64'd1);
    check("f4.addr", 64'(r_addr_out), 64'h03);
    check("f4.reg3", 64'(reg_data_out), 64'hDEADBEEF);
    xfer("f5_rd3", 40'h03_00000000, 40, 6, 40'h85_DEADBEEF, 1);
    check("f5.err", 64'(r_frame_err_out), 64'd1);

    // Clearing write to 7F still reports the error in its own reply.
    xfer("f6_clr", 40'hFF_00000000, 40, 6, 40'h85_DEADBEEF, 1);
    check("f6.err", 64'(r_frame_err_out), 64'd0);
    check("f6.addr", 64'(r_addr_out), 64'h7F);
    xfer("f7_rd10", 40'h10_00000000, 40, 6, 40'h05_00000000, 1);
    xfer("f8_wr10", 40'h90_12345678, 40, 6, 40'h05_00000000, 1);
    check("f8.data", 64'(r_data_out), 64'h12345678);
    xfer("f9_rd3", 40'h03_00000000, 40, 6, 40'h05_00000000, 1);

    // Reset after 20 SCK edges, then the master raises CS.
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      sck  = 1'b0;
      mosi = i[0];
      repeat (6) @(negedge clk);
      sck = 1'b1;
      repeat (6) @(negedge clk);
    end
    p0 = pulse_cnt;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (12) @(negedge clk);
    $display("frame midreset: aborted after 20 edges, err=%0d", r_frame_err_out);
    check("mid.err", 64'(r_frame_err_out), 64'd0);
    check("mid.pulses", 64'(pulse_cnt - p0), 64'd0);
    check("mid.oe", 64'(r_serial_oe_out), 64'd0);
    check("mid.reg3", 64'(reg_data_out), 64'd0);

    xfer("f10_wr3", 40'h83_CAFEF00D, 40, 6, 40'h05_00000000, 1);
    check("f10.err", 64'(r_frame_err_out), 64'd0);
    xfer("f11_rd0", 40'h00_00000000, 40, 6, 40'h05_CAFEF00D, 1);

    // Back-to-back writes at a faster SCK; each reply echoes the previous write.
    for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
    mregs[3] = 32'hCAFEF00D;
    mlat     = 4'd0;
    for (int k = 0; k < 5; k++) begin
      la = 4'($urandom_range(0, 15));
      ld = $urandom;
      xfer($sformatf("loop%0d", k), {1'b1, 3'b000, la, ld}, 40, 4, {8'h05, mregs[mlat]}, 1);
      check($sformatf("loop%0d.data", k), 64'(r_data_out), 64'(ld));
      mregs[la] = ld;
      mlat      = la;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
